// File: rtl/wfifo_width_conv_pkg.sv
// Shared helpers for the width-converting FIFO: log2 sizing, pointer widths
// and the parameter-legality predicate checked at elaboration by the top.
package wfifo_width_conv_pkg;

  localparam int MIN_RATIO = 2;
  localparam int MIN_DEPTH = 4;

  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= v) return r;
    end
    return 31;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Word pointer plus wrap bit.
  function automatic int wr_ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Slice pointer plus wrap bit.
  function automatic int rd_ptr_w(input int depth, input int ratio);
    return clog2(depth) + clog2(ratio) + 1;
  endfunction

  function automatic bit params_legal(input int wr_width, input int ratio, input int depth);
    return is_pow2(ratio) && (ratio >= MIN_RATIO) &&
           is_pow2(depth) && (depth >= MIN_DEPTH) &&
           ((wr_width % ratio) == 0);
  endfunction

endpackage

// File: rtl/wfifo_width_conv_ram.sv
// Simple dual-port RAM: one write port, one registered read port whose
// output register holds its value until the next read enable.
module wfifo_ram #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wfifo_width_conv.sv
// Width-converting FIFO: wide words in, RATIO narrower slices out, one clock.
// Define WFIFO_SHOWAHEAD_EN for first-word-fall-through reads.
module wfifo_width_conv
  import wfifo_width_conv_pkg::*;
#(
  parameter int WR_WIDTH  = 16,
  parameter int RATIO     = 2,
  parameter int WR_DEPTH  = 256,
  parameter int AFULL_TH  = 240,
  parameter int AEMPTY_TH = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wrreq,
  input  logic [WR_WIDTH-1:0]                   data,
  output logic                                  wrfull,
  output logic [wr_ptr_w(WR_DEPTH)-1:0]         wrusedw,
  output logic                                  almost_full,
  input  logic                                  rdreq,
  output logic [WR_WIDTH/RATIO-1:0]             q,
  output logic                                  rdempty,
  output logic [rd_ptr_w(WR_DEPTH, RATIO)-1:0]  rdusedw,
  output logic                                  almost_empty,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int RD_WIDTH = WR_WIDTH / RATIO;
  localparam int AW       = clog2(WR_DEPTH);
  localparam int SW       = clog2(RATIO);
  localparam int WPW      = AW + 1;
  localparam int RPW      = AW + SW + 1;

  localparam logic [WPW-1:0] FULL_CNT   = WPW'(WR_DEPTH);
  localparam logic [WPW-1:0] AFULL_CNT  = WPW'(AFULL_TH);
  localparam logic [RPW-1:0] AEMPTY_CNT = RPW'(AEMPTY_TH);

  if (!params_legal(WR_WIDTH, RATIO, WR_DEPTH)) begin : g_param_check
    $error("wfifo_width_conv: RATIO and WR_DEPTH must be powers of two and RATIO must divide WR_WIDTH");
  end

  function automatic logic [RD_WIDTH-1:0] pick_slice(input logic [WR_WIDTH-1:0] word,
                                                     input logic [SW-1:0]       idx);
    logic [SW-1:0] pos;
    pos = (MSB_FIRST != 0) ? ~idx : idx;
    return word[int'(pos)*RD_WIDTH +: RD_WIDTH];
  endfunction

  logic [WPW-1:0]      wp_q, wp_d;
  logic [RPW-1:0]      rp_q, rp_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic                wr_acc, rd_acc;
  logic                ram_re;
  logic [AW-1:0]       ram_raddr;
  logic [WR_WIDTH-1:0] ram_rdata;
  logic [SW-1:0]       slice_idx;
  logic [AW-1:0]       rd_word;

  assign rd_word      = rp_q[RPW-2:SW];
  assign rdusedw      = {wp_q, {SW{1'b0}}} - rp_q;
  // A word stays occupied until its last slice has been read.
  assign wrusedw      = wp_q - rp_q[RPW-1:SW];
  assign wrfull       = (wrusedw == FULL_CNT);
  assign almost_full  = (wrusedw >= AFULL_CNT);
  assign almost_empty = (rdusedw <= AEMPTY_CNT);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign wr_acc       = wrreq && !wrfull;
  assign q            = pick_slice(ram_rdata, slice_idx);

`ifdef WFIFO_SHOWAHEAD_EN
  // RAM output register is the head word; it is refilled when the head's
  // last slice is taken and another complete word is already stored.
  logic head_vld_q, head_vld_d;

  assign rdempty   = !head_vld_q;
  assign slice_idx = rp_q[SW-1:0];

  always_comb begin
    rd_acc     = rdreq && head_vld_q;
    head_vld_d = head_vld_q;
    ram_re     = 1'b0;
    ram_raddr  = rd_word;
    if (!head_vld_q) begin
      if (wrusedw != '0) begin
        ram_re     = 1'b1;
        head_vld_d = 1'b1;
      end
    end else if (rd_acc && (&rp_q[SW-1:0])) begin
      if (wrusedw > WPW'(1)) begin
        ram_re     = 1'b1;
        ram_raddr  = rd_word + AW'(1);
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) head_vld_q <= 1'b0;
    else     head_vld_q <= head_vld_d;
  end
`else
  // The slice index is captured with the read so q holds between reads.
  logic [SW-1:0] sel_q, sel_d;

  assign rdempty   = (rdusedw == '0);
  assign slice_idx = sel_q;

  always_comb begin
    rd_acc    = rdreq && !rdempty;
    ram_re    = rd_acc;
    ram_raddr = rd_word;
    sel_d     = rd_acc ? rp_q[SW-1:0] : sel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= '0;
    else     sel_q <= sel_d;
  end
`endif

  always_comb begin
    wp_d        = wp_q + WPW'(wr_acc);
    rp_d        = rp_q + RPW'(rd_acc);
    overflow_d  = wrreq && wrfull;
    underflow_d = rdreq && rdempty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q        <= '0;
      rp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  wfifo_ram #(
    .DW (WR_WIDTH),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wp_q[AW-1:0]),
    .wdata (data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_wfifo_width_conv.sv
// Randomised scoreboard bench for wfifo_width_conv (default parameters).
module tb_wfifo_width_conv;

  localparam int WW = 16;
  localparam int R  = 2;
  localparam int D  = 256;
  localparam int RW = WW / R;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrreq;
  logic [WW-1:0] data;
  logic          wrfull;
  logic [8:0]    wrusedw;
  logic          almost_full;
  logic          rdreq;
  logic [RW-1:0] q;
  logic          rdempty;
  logic [9:0]    rdusedw;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  wfifo_width_conv #(
    .WR_WIDTH(WW), .RATIO(R), .WR_DEPTH(D),
    .AFULL_TH(240), .AEMPTY_TH(4), .MSB_FIRST(0)
  ) dut (
    .clk(clk), .rst(rst), .wrreq(wrreq), .data(data), .wrfull(wrfull),
    .wrusedw(wrusedw), .almost_full(almost_full), .rdreq(rdreq), .q(q),
    .rdempty(rdempty), .rdusedw(rdusedw), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain queue of slices plus a count of slices read.
  logic [RW-1:0] mq[$];
  logic [RW-1:0] exp_q[$];
  int            m_slices = 0;
  int            m_reads  = 0;
  logic          exp_ovf  = 1'b0;
  logic          exp_udf  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int m_words();
    return (m_slices + (m_reads % R)) / R;
  endfunction

  task automatic check_state();
    chk("rdusedw", rdusedw, m_slices);
    chk("wrusedw", wrusedw, m_words());
    chk("rdempty", rdempty, (m_slices == 0));
    chk("wrfull", wrfull, (m_words() == D));
    chk("almost_full", almost_full, (m_words() >= 240));
    chk("almost_empty", almost_empty, (m_slices <= 4));
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_udf);
  endtask

  // Called on a falling edge: check the state, drive one cycle, update model.
  task automatic step(input logic wr, input logic [WW-1:0] d, input logic rd);
    logic full, empty;
    check_state();
    wrreq = wr;
    data  = d;
    rdreq = rd;
    full  = (m_words() == D);
    empty = (m_slices == 0);
    exp_ovf = wr && full;
    exp_udf = rd && empty;
    if (rd && !empty) begin
      exp_q.push_back(mq.pop_front());
      m_slices--;
      m_reads++;
    end
    if (wr && !full) begin
      for (int k = 0; k < R; k++) mq.push_back(d[k*RW +: RW]);
      m_slices += R;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = '0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_q.delete();
    m_slices = 0;
    m_reads  = 0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

`ifndef WFIFO_SHOWAHEAD_EN
  // Monitor: every accepted read must show the scoreboard's next slice.
  always @(posedge clk) begin
    if (!rst && rdreq && !rdempty) begin
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL q_extra actual=%0h required=no_read at %0t", q, $time);
      end else begin
        chk("q", q, exp_q.pop_front());
      end
    end
  end
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_state();
    chk("q_reset", q, 0);

`ifdef WFIFO_SHOWAHEAD_EN
    begin
      logic [WW-1:0] words [4];
      logic [WW-1:0] w;
      wrreq = 1'b1; data = 16'hABCD;
      @(negedge clk);
      wrreq = 1'b0;
      chk("sa_empty_first", rdempty, 1);
      @(negedge clk);
      chk("sa_empty_second", rdempty, 0);
      chk("sa_q_lo", q, 8'hCD);
      chk("sa_rdusedw", rdusedw, 2);
      rdreq = 1'b1;
      @(negedge clk);
      chk("sa_q_hi", q, 8'hAB);
      chk("sa_not_empty", rdempty, 0);
      @(negedge clk);
      rdreq = 1'b0;
      chk("sa_empty_after", rdempty, 1);
      chk("sa_rdusedw_zero", rdusedw, 0);
      for (int k = 0; k < 4; k++) begin
        words[k] = 16'($urandom);
        wrreq = 1'b1; data = words[k];
        @(negedge clk);
      end
      wrreq = 1'b0;
      repeat (3) @(negedge clk);
      rdreq = 1'b1;
      for (int s = 0; s < 8; s++) begin
        w = words[s/2];
        chk("sa_stream_q", q, w[(s%2)*RW +: RW]);
        chk("sa_stream_vld", rdempty, 0);
        @(negedge clk);
      end
      rdreq = 1'b0;
      chk("sa_stream_end", rdempty, 1);
      rdreq = 1'b1;
      @(negedge clk);
      rdreq = 1'b0;
      chk("sa_underflow", underflow, 1);
      @(negedge clk);
      chk("sa_underflow_clear", underflow, 0);
    end
`else
    // Read from empty: one underflow pulse, q untouched.
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("q_after_underflow", q, 0);
    step(1'b0, '0, 1'b0);

    // Fill to capacity, then one rejected write.
    for (int i = 0; i < D; i++) step(1'b1, WW'(1024 + i), 1'b0);
    step(1'b1, 16'hDEAD, 1'b0);
    step(1'b0, '0, 1'b0);

    // Half a word freed keeps it full; the second slice frees the word.
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 2*D - 2; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Simultaneous read and write at rdusedw=10.
    for (int i = 0; i < 5; i++) step(1'b1, WW'($urandom), 1'b0);
    step(1'b1, WW'($urandom), 1'b1);
    step(1'b0, '0, 1'b0);

    // Random phases: fill past full, drain past empty, sustained wraparound.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(99) < 90), WW'($urandom), ($urandom_range(99) < 10));
    for (int i = 0; i < 700; i++)
      step(($urandom_range(99) < 5), WW'($urandom), ($urandom_range(99) < 97));
    for (int i = 0; i < 600; i++)
      step(($urandom_range(99) < 50), WW'($urandom), ($urandom_range(99) < 95));

    // Reset while holding data, then resume.
    for (int i = 0; i < 20; i++) step(1'b1, WW'($urandom), 1'b0);
    do_reset();
    check_state();
    chk("q_mid_reset", q, 0);
    for (int i = 0; i < 10; i++) step(1'b1, WW'($urandom), 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_state();
    chk("scoreboard_drained", exp_q.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wfifo_width_conv.md
# wfifo_width_conv

Single-clock, parametrised width-converting FIFO. It accepts wide words on the write side and delivers them as narrower slices on the read side, generalising the 16-to-8-bit FIFO to any power-of-two ratio and depth. It adds almost-full/empty thresholds, overflow/underflow pulses and an optional show-ahead read mode. It sits between wide producers (ADC/packet assemblers) and byte-wide consumers (UART/serial TX) inside one clock domain.

## Interface
- `WR_WIDTH`, 16, write word width; must be a multiple of `RATIO`.
- `RATIO`, 2, slices per write word; power of two, ≥2. `RD_WIDTH = WR_WIDTH/RATIO`.
- `WR_DEPTH`, 256, capacity in write words; power of two, ≥4.
- `AFULL_TH`, 240, `almost_full` threshold in write words.
- `AEMPTY_TH`, 4, `almost_empty` threshold in read slices.
- `MSB_FIRST`, 0, 0 = least-significant slice read first.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wrreq` in 1: write request.
- `data` in `WR_WIDTH`: write word.
- `wrfull` out 1: no free write word.
- `wrusedw` out `clog2(WR_DEPTH)+1`: whole or partial words occupied.
- `almost_full` out 1: `wrusedw >= AFULL_TH`.
- `rdreq` in 1: read request.
- `q` out `RD_WIDTH`: read slice.
- `rdempty` out 1: no readable slice.
- `rdusedw` out `clog2(WR_DEPTH*RATIO)+1`: slices stored.
- `almost_empty` out 1: `rdusedw <= AEMPTY_TH`.
- `overflow` out 1: one-cycle pulse on a write attempted while full.
- `underflow` out 1: one-cycle pulse on a read attempted while empty.

## Operation
- Storage: `WR_DEPTH` × `WR_WIDTH` memory.
  - Write pointer `wp` counts words, with an extra wrap bit.
  - Read pointer `rp` counts slices, with an extra wrap bit. Upper bits give the word address; low `clog2(RATIO)` bits give the slice index.
- Write accepted iff `wrreq && !wrfull`. The accepted word is stored at `wp` and `wp` increments.
- Read accepted iff `rdreq && !rdempty`. `q` receives the slice selected by the slice index: index 0 is the LSB slice, or the MSB slice when `MSB_FIRST=1`. `rp` then increments.
- `rdusedw = wp*RATIO - rp` (modulo pointer width).
- `wrusedw = wp - rp[MSB:clog2(RATIO)]`. A word is freed only after its last slice has been read.
- `wrfull = (wrusedw == WR_DEPTH)`.
- `rdempty = (rdusedw == 0)`.
- Simultaneous accepted read and write: both pointers advance and the counts change by `+RATIO-1` slices.
- Acceptance uses the flag values at the start of the cycle. A write while full is rejected even if a read in the same cycle frees a word. A read while empty is rejected even if a write lands in the same cycle.
- A rejected write pulses `overflow`; a rejected read pulses `underflow`. Neither has any other effect.
- Pointer wrap is natural binary rollover; no special casing.
- Reset mid-operation discards all contents and returns every output to its reset value.

## Timing
- Reset values:
  - `q=0`, `rdempty=1`, `wrfull=0`
  - `wrusedw=0`, `rdusedw=0`
  - `almost_empty=1`, `almost_full=0`
  - `overflow=0`, `underflow=0`
- All flags and counts are decoded from registered pointers and are valid the cycle after the causing edge. After the first write edge, `rdempty` falls in the next cycle.
- Normal mode: `q` is registered and updates on the edge where the read is accepted, giving 1-cycle latency. `q` holds its value otherwise.
- `overflow`/`underflow` are registered and high for exactly the cycle after the rejected request.

## Configuration
- `WFIFO_SHOWAHEAD_EN` defined: first-word-fall-through.
  - A prefetch register presents the head slice on `q` while `rdempty=0`; `rdreq` acknowledges it.
  - `rdempty` deasserts one cycle later than in normal mode after a write into an empty FIFO.
  - `rdusedw` includes the prefetched slice.
  - Back-to-back reads stream one slice per cycle.
- Undefined: normal mode as described under Operation and Timing.

## Structure
- Package `wfifo_width_conv_pkg`: `clog2` function, pointer-width constants, parameter-legality checks (elaboration `$error` on non-power-of-two `RATIO`/`WR_DEPTH` or a `WR_WIDTH` that is not divisible by `RATIO`).
- Sub-module `wfifo_ram`: simple dual-port RAM, one write port and one registered read port, inferrable as block RAM.

## Test plan
- Reset then idle: all outputs at reset values; `rdreq=1` for 1 cycle → `underflow` pulses once, `q` stays 0.
- Defaults, write 256 words `1024..1279` → `wrfull=1` after the 256th, `wrusedw=256`, `rdusedw=512`, `almost_full` from word 240. A 257th write → `overflow` pulse, contents unchanged.
- Read 512 slices → `q` = `0x00,0x04,0x01,0x04,…,0xFF,0x04`; `rdempty=1` after the last; `almost_empty` from `rdusedw=4`.
- Full FIFO, single read: `wrfull` stays 1 (half word freed); second read → `wrfull=0`, `wrusedw=255`.
- Simultaneous write and read with `rdusedw=10` → next cycle `rdusedw=11`; sustained 600 cycles of wraparound with a scoreboard shows no data loss.
- `WFIFO_SHOWAHEAD_EN` defined, single write of `0xABCD` → `q=0xCD` with `rdempty=0` two cycles after the write edge; `rdreq` → `q=0xAB`; next `rdreq` → `rdempty=1`.
